// File: rtl/lane_judge.sv
// Rhythm-game lane judge: synchronises the lane key, tracks one falling block and
// grades hits. Define LANE_JUDGE_PENALTY_EN to penalise presses made outside the window.
module lane_judge (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic [9:0] block_h,
  input  logic       stop_or_endgame,
  output logic       hit_perfect,
  output logic       hit_good,
  output logic       miss,
  output logic [9:0] score,
  output logic [6:0] combo,
  output logic [6:0] max_combo,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALLING = 2'd1,
    WINDOW  = 2'd2,
    JUDGED  = 2'd3
  } state_t;

  localparam logic [9:0] H_OFF       = 10'd720;
  localparam logic [9:0] H_WIN_LO    = 10'd600;
  localparam logic [9:0] H_WIN_HI    = 10'd680;
  localparam logic [9:0] H_PERF_LO   = 10'd630;
  localparam logic [9:0] H_PERF_HI   = 10'd650;
  localparam logic [9:0] SCORE_MAX   = 10'd999;
  localparam logic [6:0] COMBO_MAX   = 7'd127;

  state_t      cur, nxt;
  logic        s1, s2, s3;
  logic [9:0]  prev_h;
  logic        key_rise, new_block, in_window, in_perfect;
  logic        do_perfect, do_good, do_miss, do_penalty;
  logic [10:0] score_sum;
  logic [9:0]  score_hit;
  logic [6:0]  combo_inc;

  assign key_rise   = s2 & ~s3;
  assign new_block  = (block_h < prev_h);
  assign in_window  = (block_h >= H_WIN_LO) && (block_h <= H_WIN_HI);
  assign in_perfect = (block_h >= H_PERF_LO) && (block_h <= H_PERF_HI);
  assign state      = cur;

  assign score_sum = {1'b0, score} + (do_perfect ? 11'd3 : 11'd1);
  assign score_hit = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
  assign combo_inc = (combo == COMBO_MAX) ? COMBO_MAX : combo + 7'd1;

  always_comb begin
    nxt        = cur;
    do_perfect = 1'b0;
    do_good    = 1'b0;
    do_miss    = 1'b0;
    do_penalty = 1'b0;
    case (cur)
      IDLE: begin
        if (new_block) nxt = FALLING;
      end
      FALLING: begin
        if (new_block)            nxt = FALLING;
        else if (in_window)       nxt = WINDOW;
        else if (block_h == H_OFF) nxt = IDLE;
`ifdef LANE_JUDGE_PENALTY_EN
        else if (key_rise)        do_penalty = 1'b1;
`endif
      end
      WINDOW: begin
        // A new block takes priority: the old one is dropped unjudged.
        if (new_block) begin
          nxt = FALLING;
        end else if (key_rise) begin
          nxt        = JUDGED;
          do_perfect = in_window & in_perfect;
          do_good    = in_window & ~in_perfect;
          do_miss    = ~in_window;
        end else if (block_h > H_WIN_HI) begin
          nxt     = JUDGED;
          do_miss = 1'b1;
        end
      end
      JUDGED: begin
        if (new_block)             nxt = FALLING;
        else if (block_h == H_OFF) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (stop_or_endgame) begin
      nxt        = cur;
      do_perfect = 1'b0;
      do_good    = 1'b0;
      do_miss    = 1'b0;
      do_penalty = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      prev_h      <= H_OFF;
      hit_perfect <= 1'b0;
      hit_good    <= 1'b0;
      miss        <= 1'b0;
      score       <= 10'd0;
      combo       <= 7'd0;
      max_combo   <= 7'd0;
    end else begin
      // Synchroniser keeps running while frozen so a press made then is consumed.
      s1          <= key;
      s2          <= s1;
      s3          <= s2;
      cur         <= nxt;
      hit_perfect <= do_perfect;
      hit_good    <= do_good;
      miss        <= do_miss | do_penalty;
      if (!stop_or_endgame) prev_h <= block_h;
      if (do_perfect || do_good) begin
        score     <= score_hit;
        combo     <= combo_inc;
        max_combo <= (combo_inc > max_combo) ? combo_inc : max_combo;
      end else if (do_miss) begin
        combo <= 7'd0;
      end else if (do_penalty) begin
        score <= (score == 10'd0) ? 10'd0 : score - 10'd1;
        combo <= 7'd0;
      end
    end
  end

endmodule

// File: doc/lane_judge.md
LANE_JUDGE -- requirements
Module: lane_judge

Interface
REQ-001 SHALL have port: clk  input  1  game clock (clk_beat_ten domain, one clock), rising-edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: key  input  1  raw lane button level, asynchronous to clk.
REQ-004 SHALL have port: block_h  input  10  lane block height from the block generator; 720 = off-screen; increments 1 per clk while falling.
REQ-005 SHALL have port: stop_or_endgame  input  1  freeze; high holds all judge state.
REQ-006 SHALL have ports: hit_perfect, hit_good, miss  output  1 each  one-cycle registered pulses.
REQ-007 SHALL have ports: score  output  10, combo  output  7, max_combo  output  7, all registered.
REQ-008 SHALL have port: state  output  2  FSM state (IDLE=0, FALLING=1, WINDOW=2, JUDGED=3).

Function
REQ-009 SHALL synchronise key through two flops (s1, s2) plus delay flop s3; key_rise = s2 & ~s3.
REQ-010 SHALL register prev_h = block_h each clk; new_block = (block_h < prev_h).
REQ-011 Window: block_h 600..680 inclusive; perfect sub-window 630..650; rest of window is good.
REQ-012 IDLE -> FALLING on new_block; no other exit.
REQ-013 FALLING -> WINDOW when block_h enters 600..680; FALLING -> IDLE when block_h = 720 without passing through the window.
REQ-014 WINDOW + key_rise: hit_perfect or hit_good pulse next cycle, -> JUDGED.
REQ-015 WINDOW, block_h > 680 with no key_rise: miss pulse, combo := 0, -> JUDGED.
REQ-016 JUDGED -> IDLE when block_h = 720; key_rise ignored in JUDGED and IDLE.
REQ-017 new_block in any state SHALL force FALLING; a key_rise in that same cycle SHALL be ignored; an unjudged block in WINDOW SHALL be dropped without a miss.
REQ-018 Perfect: score += 3; good: score += 1; score saturates at 999.
REQ-019 Any hit: combo += 1, saturating at 127; max_combo := max(max_combo, new combo) in the same cycle.
REQ-020 Latency: key first sampled high at edge k SHALL produce a hit pulse high in the cycle after edge k+2. Judging uses block_h at edge k+2.
REQ-021 stop_or_endgame high: FSM, score, combo, max_combo and prev_h SHALL hold; pulses 0. Sync flops keep running.
REQ-022 A key_rise arriving while frozen SHALL be lost, not queued.
REQ-023 At most one of hit_perfect, hit_good and miss SHALL be high in any cycle.

Reset
REQ-024 rst high SHALL asynchronously set state = IDLE; score, combo, max_combo = 0; pulses = 0; s1..s3 = 0; prev_h = 720.
REQ-025 rst asserted mid-block SHALL discard the block; after release the FSM waits in IDLE for the next new_block.

Configuration
REQ-026 Macro LANE_JUDGE_PENALTY_EN defined: key_rise in FALLING SHALL score -= 1 (floor 0), combo := 0, and pulse miss; state unchanged.
REQ-027 Macro LANE_JUDGE_PENALTY_EN undefined: key_rise in FALLING SHALL be ignored with no output change.

Verification
REQ-028 Block 120->720, key pressed when block_h = 640 -> hit_perfect once, score 3, combo 1, max_combo 1, state JUDGED then IDLE.
REQ-029 Key pressed at block_h = 605 -> hit_good, score +1; no press through the window -> miss at block_h = 681, combo 0, max_combo kept.
REQ-030 score preset to 998 via hits, then a perfect hit -> score 999; 128 consecutive hits -> combo 127.
REQ-031 new_block with simultaneous key_rise while in WINDOW -> state FALLING, no pulse, score unchanged.
REQ-032 stop_or_endgame high for 50 cycles inside the window with a key press -> no pulse, outputs frozen; rst mid-block -> all zero, IDLE.
REQ-033 Key pressed at block_h = 300: with LANE_JUDGE_PENALTY_EN, score 5 -> 4, combo 0, miss pulse; without the macro, no change.
